// File: rtl/serial_adder_ctrl_if.sv
// Request/result bundle between a master and the bit-serial adder controller.
// The master drives the request and operands; the controller drives status and result.
interface serial_adder_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum_out;
    logic             cout;

    modport master (
        output start, a_in, b_in, cin,
        input  busy, done, sum_out, cout
    );

    modport slave (
        input  start, a_in, b_in, cin,
        output busy, done, sum_out, cout
    );
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: one 1-bit full adder is reused for WIDTH cycles,
// LSB first, with the carry kept in a flop between cycles.
// start/busy/done handshake; the result registers hold until the next completion.

// Shared 1-bit datapath element.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ c;
    assign cout = (a & b) | (a & c) | (b & c);
endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    serial_adder_ctrl_if.slave  bus
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [WIDTH-1:0]   sum_sh_q;
    logic               carry_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   sum_q;
    logic               cout_q;
    logic               busy_q;
    logic               done_q;

    logic [WIDTH-1:0]   a_d;
    logic [WIDTH-1:0]   b_d;
    logic [WIDTH-1:0]   sum_sh_d;
    logic [CNT_W-1:0]   cnt_d;
    logic               last_bit;

    logic               fa_sum;
    logic               fa_cout;

    // The full adder always looks at the LSBs of the latched operands and the held carry.
    full_adder u_fa (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .c    (carry_q),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    // Next values of the shift/count datapath for one ADD step.
    always_comb begin
        a_d      = a_q >> 1;
        b_d      = b_q >> 1;
        sum_sh_d = {fa_sum, sum_sh_q[WIDTH-1:1]};
        cnt_d    = cnt_q + CNT_W'(1);
        last_bit = (cnt_q == CNT_W'(WIDTH - 1));
    end

    // Control FSM with registered busy/done and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            sum_sh_q <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        a_q     <= bus.a_in;
                        b_q     <= bus.b_in;
                        carry_q <= bus.cin;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ADD;
                    end
                end
                ADD: begin
                    a_q      <= a_d;
                    b_q      <= b_d;
                    sum_sh_q <= sum_sh_d;
                    carry_q  <= fa_cout;
                    cnt_q    <= cnt_d;
                    // The final bit goes straight into the result; sum_sh_q is not needed after this.
                    if (last_bit) begin
                        sum_q   <= sum_sh_d;
                        cout_q  <= fa_cout;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    // Any start seen here is dropped; the master must present it again in IDLE.
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.sum_out = sum_q;
    assign bus.cout    = cout_q;
endmodule
